// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared source codes and occupancy state encoding for alu_result_collector
package alu_pkg;

    localparam int SRC_W = 2;

    // Source codes follow the ALU_FUN unit-select encoding
    localparam logic [SRC_W-1:0] SRC_ARITH = 2'b00;
    localparam logic [SRC_W-1:0] SRC_LOGIC = 2'b01;
    localparam logic [SRC_W-1:0] SRC_CMP   = 2'b10;
    localparam logic [SRC_W-1:0] SRC_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } fifo_state_t;

endpackage

// File: rtl/alu_res_fifo2.sv
// rtl/alu_res_fifo2.sv - 2-entry result FIFO with EMPTY/ONE/TWO occupancy FSM
module alu_res_fifo2
    import alu_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full
);

    fifo_state_t            state_q, state_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0][WIDTH-1:0]  mem_q, mem_d;
    logic                   pop_ok;
    logic                   push_ok;

    assign valid   = (state_q != ST_EMPTY);
    assign full    = (state_q == ST_TWO);
    assign rd_data = valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        pop_ok   = pop && valid;
        // A full FIFO still accepts when the head leaves in the same cycle
        push_ok  = push && (!full || pop_ok);

        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            ST_EMPTY: if (push_ok) state_d = ST_ONE;
            ST_ONE: begin
                if (push_ok && !pop_ok)      state_d = ST_TWO;
                else if (pop_ok && !push_ok) state_d = ST_EMPTY;
            end
            ST_TWO:   if (pop_ok && !push_ok) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/alu_result_collector.sv
// rtl/alu_result_collector.sv - collects one-hot ALU unit results into a 2-deep ordered buffer
// Optional push statistics output STAT_CNT enabled by macro ALU_RES_STATS_EN.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] Arith_OUT,
    input  logic [DATA_WIDTH-1:0] Logic_OUT,
    input  logic [DATA_WIDTH-1:0] CMP_OUT,
    input  logic [DATA_WIDTH-1:0] Shift_OUT,
    input  logic                  Arith_Flag,
    input  logic                  Logic_Flag,
    input  logic                  CMP_Flag,
    input  logic                  Shift_Flag,
    output logic [DATA_WIDTH-1:0] ALU_OUT,
    output logic [SRC_W-1:0]      ALU_SRC,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  OVERFLOW,
    output logic                  MULTI_ERR,
    input  logic                  CLR_ERR
`ifdef ALU_RES_STATS_EN
    ,
    output logic [31:0]           STAT_CNT
`endif
);

    logic [2:0]                  flag_cnt;
    logic                        push_one;
    logic                        multi_set;
    logic                        ovf_set;
    logic                        pop;
    logic                        fifo_full;
    logic [SRC_W-1:0]            push_src;
    logic [DATA_WIDTH-1:0]       push_res;
    logic [DATA_WIDTH+SRC_W-1:0] rd_data;
    logic                        ovf_q, ovf_d;
    logic                        mul_q, mul_d;

    always_comb begin
        flag_cnt = 3'(Arith_Flag) + 3'(Logic_Flag) + 3'(CMP_Flag) + 3'(Shift_Flag);
        push_one = (flag_cnt == 3'd1);
        multi_set = (flag_cnt > 3'd1);
        push_src = SRC_ARITH;
        push_res = Arith_OUT;
        if (Logic_Flag) begin
            push_src = SRC_LOGIC;
            push_res = Logic_OUT;
        end else if (CMP_Flag) begin
            push_src = SRC_CMP;
            push_res = CMP_OUT;
        end else if (Shift_Flag) begin
            push_src = SRC_SHIFT;
            push_res = Shift_OUT;
        end
    end

    assign pop     = OUT_VALID && OUT_READY;
    assign ovf_set = push_one && fifo_full && !pop;

    // Set events win over a same-cycle clear
    always_comb begin
        ovf_d = ovf_q;
        mul_d = mul_q;
        if (ovf_set)      ovf_d = 1'b1;
        else if (CLR_ERR) ovf_d = 1'b0;
        if (multi_set)    mul_d = 1'b1;
        else if (CLR_ERR) mul_d = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
            mul_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            mul_q <= mul_d;
        end
    end

    assign OVERFLOW  = ovf_q;
    assign MULTI_ERR = mul_q;

    alu_res_fifo2 #(
        .WIDTH (DATA_WIDTH + SRC_W)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (push_one),
        .wr_data ({push_src, push_res}),
        .pop     (pop),
        .rd_data (rd_data),
        .valid   (OUT_VALID),
        .full    (fifo_full)
    );

    assign ALU_OUT = rd_data[DATA_WIDTH-1:0];
    assign ALU_SRC = rd_data[DATA_WIDTH+SRC_W-1:DATA_WIDTH];

`ifdef ALU_RES_STATS_EN
    logic [3:0][7:0] stat_q, stat_d;
    logic            push_acc;

    assign push_acc = push_one && (!fifo_full || pop);

    always_comb begin
        stat_d = stat_q;
        if (push_acc && (stat_q[push_src] != 8'hFF)) begin
            stat_d[push_src] = stat_q[push_src] + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) stat_q <= '0;
        else     stat_q <= stat_d;
    end

    assign STAT_CNT = stat_q;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// tb/tb_alu_result_collector.sv - directed and random checks of alu_result_collector against a queue model
module tb_alu_result_collector;

    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
    logic          Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
    logic [DW-1:0] ALU_OUT;
    logic [1:0]    ALU_SRC;
    logic          OUT_VALID, OUT_READY, OVERFLOW, MULTI_ERR, CLR_ERR;
`ifdef ALU_RES_STATS_EN
    logic [31:0]   STAT_CNT;
`endif

    alu_result_collector #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Arith_OUT  (Arith_OUT),
        .Logic_OUT  (Logic_OUT),
        .CMP_OUT    (CMP_OUT),
        .Shift_OUT  (Shift_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_Flag (Logic_Flag),
        .CMP_Flag   (CMP_Flag),
        .Shift_Flag (Shift_Flag),
        .ALU_OUT    (ALU_OUT),
        .ALU_SRC    (ALU_SRC),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OVERFLOW   (OVERFLOW),
        .MULTI_ERR  (MULTI_ERR),
        .CLR_ERR    (CLR_ERR)
`ifdef ALU_RES_STATS_EN
        ,
        .STAT_CNT   (STAT_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]    src;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf;
    bit   m_mul;
    int   m_cnt[4];
    int   errors = 0;
    int   checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd16();
        return DW'($urandom());
    endfunction

    task automatic check_model();
        check_eq("valid", 32'(OUT_VALID), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check_eq("out", 32'(ALU_OUT), 32'(mq[0].data));
            check_eq("src", 32'(ALU_SRC), 32'(mq[0].src));
        end
        check_eq("ovf", 32'(OVERFLOW), 32'(m_ovf));
        check_eq("mul", 32'(MULTI_ERR), 32'(m_mul));
`ifdef ALU_RES_STATS_EN
        check_eq("stat", STAT_CNT, {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
`endif
    endtask

    // One clock: drive at negedge, apply the rules at posedge, compare shortly after
    task automatic cyc(input logic [3:0] fl, input logic [DW-1:0] a, input logic [DW-1:0] l,
                       input logic [DW-1:0] c, input logic [DW-1:0] s, input logic rdy, input logic clr);
        bit   pop, ovf_set, mul_set;
        int   n;
        ent_t e;
        @(negedge CLK);
        {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = fl;
        Arith_OUT = a; Logic_OUT = l; CMP_OUT = c; Shift_OUT = s;
        OUT_READY = rdy; CLR_ERR = clr;
        @(posedge CLK);
        n = $countones(fl);
        pop = (mq.size() > 0) && rdy;
        ovf_set = (n == 1) && (mq.size() == 2) && !pop;
        mul_set = (n > 1);
        if (pop) void'(mq.pop_front());
        if (n == 1 && !ovf_set) begin
            for (int i = 0; i < 4; i++) if (fl[i]) e.src = 2'(i);
            case (e.src)
                2'd0: e.data = a;
                2'd1: e.data = l;
                2'd2: e.data = c;
                default: e.data = s;
            endcase
            mq.push_back(e);
            if (m_cnt[e.src] < 255) m_cnt[e.src]++;
        end
        m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_mul = mul_set ? 1'b1 : (clr ? 1'b0 : m_mul);
        #1;
        check_model();
    endtask

    task automatic idle(input logic rdy, input logic clr);
        cyc(4'b0000, rnd16(), rnd16(), rnd16(), rnd16(), rdy, clr);
    endtask

    task automatic push1(input int unit, input logic [DW-1:0] v, input logic rdy);
        logic [DW-1:0] d[4];
        for (int i = 0; i < 4; i++) d[i] = rnd16();
        d[unit] = v;
        cyc(4'(1 << unit), d[0], d[1], d[2], d[3], rdy, 1'b0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_mul = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(OUT_VALID), 32'd0);
        check_eq({tag, "_out"}, 32'(ALU_OUT), 32'd0);
        check_eq({tag, "_src"}, 32'(ALU_SRC), 32'd0);
        check_eq({tag, "_ovf"}, 32'(OVERFLOW), 32'd0);
        check_eq({tag, "_mul"}, 32'(MULTI_ERR), 32'd0);
`ifdef ALU_RES_STATS_EN
        check_eq({tag, "_stat"}, STAT_CNT, 32'd0);
`endif
    endtask

    initial begin
        RST = 1'b1;
        {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = '0;
        Arith_OUT = '0; Logic_OUT = '0; CMP_OUT = '0; Shift_OUT = '0;
        OUT_READY = 1'b0; CLR_ERR = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_zero_outputs("reset");
        @(negedge CLK);
        RST = 1'b0;

        // Single push, latency one, then empty
        push1(0, 16'h1234, 1'b1);
        check_eq("lat_out", 32'(ALU_OUT), 32'h1234);
        check_eq("lat_src", 32'(ALU_SRC), 32'd0);
        check_eq("lat_valid", 32'(OUT_VALID), 32'd1);
        idle(1'b1, 1'b0);
        check_eq("lat_empty", 32'(OUT_VALID), 32'd0);

        // Third push into a full, stalled buffer is dropped
        push1(1, 16'h0001, 1'b0);
        push1(2, 16'h0002, 1'b0);
        push1(3, 16'h0003, 1'b0);
        check_eq("ovf_set", 32'(OVERFLOW), 32'd1);
        check_eq("ovf_head", 32'(ALU_OUT), 32'h0001);
        check_eq("ovf_hsrc", 32'(ALU_SRC), 32'd1);
        idle(1'b1, 1'b0);
        check_eq("ovf_2nd", 32'(ALU_OUT), 32'h0002);
        check_eq("ovf_2src", 32'(ALU_SRC), 32'd2);
        idle(1'b1, 1'b0);
        check_eq("ovf_drained", 32'(OUT_VALID), 32'd0);
        idle(1'b0, 1'b1);
        check_eq("ovf_clr", 32'(OVERFLOW), 32'd0);

        // Push while full with a simultaneous pop
        push1(0, 16'h00AA, 1'b0);
        push1(1, 16'h00BB, 1'b0);
        push1(3, 16'h00FF, 1'b1);
        check_eq("pp_noovf", 32'(OVERFLOW), 32'd0);
        check_eq("pp_head", 32'(ALU_OUT), 32'h00BB);
        idle(1'b1, 1'b0);
        check_eq("pp_tail", 32'(ALU_OUT), 32'h00FF);
        check_eq("pp_tsrc", 32'(ALU_SRC), 32'd3);
        idle(1'b1, 1'b0);

        // Two flags at once: no push, sticky error; clear on an error-free cycle
        cyc(4'b0011, rnd16(), rnd16(), rnd16(), rnd16(), 1'b1, 1'b0);
        check_eq("multi_set", 32'(MULTI_ERR), 32'd1);
        check_eq("multi_nopush", 32'(OUT_VALID), 32'd0);
        cyc(4'b0101, rnd16(), rnd16(), rnd16(), rnd16(), 1'b1, 1'b1);
        check_eq("multi_prio", 32'(MULTI_ERR), 32'd1);
        idle(1'b1, 1'b1);
        check_eq("multi_clr", 32'(MULTI_ERR), 32'd0);

        // Asynchronous reset mid-clock with two entries held
        push1(0, 16'h0011, 1'b0);
        push1(1, 16'h0022, 1'b0);
        #3 RST = 1'b1;
        #1;
        check_zero_outputs("mid_rst");
        model_reset();
        {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = '0;
        @(negedge CLK);
        RST = 1'b0;
        push1(0, 16'h0033, 1'b0);
        check_eq("post_rst", 32'(ALU_OUT), 32'h0033);
        idle(1'b1, 1'b0);

        // Saturating Arith counter
        for (int i = 0; i < 300; i++) push1(0, rnd16(), 1'b1);
`ifdef ALU_RES_STATS_EN
        check_eq("stat_sat", {24'd0, STAT_CNT[7:0]}, 32'd255);
        check_eq("stat_other", {8'd0, STAT_CNT[31:8]}, 32'd0);
`endif
        idle(1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            logic [3:0] fl;
            r = $urandom_range(0, 9);
            if (r < 6)      fl = 4'(1 << $urandom_range(0, 3));
            else if (r < 8) fl = 4'b0000;
            else            fl = 4'($urandom());
            cyc(fl, rnd16(), rnd16(), rnd16(), rnd16(),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of every unit result and of ALU_OUT.
REQ-002 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports Arith_OUT / Logic_OUT / CMP_OUT / Shift_OUT  input  DATA_WIDTH each  per-unit results.
REQ-005 SHALL have ports Arith_Flag / Logic_Flag / CMP_Flag / Shift_Flag  input  1 each  result valid this cycle.
REQ-006 SHALL have port ALU_OUT  output  DATA_WIDTH  head-of-buffer result.
REQ-007 SHALL have port ALU_SRC  output  2  producing unit of head entry: 00 Arith, 01 Logic, 10 CMP, 11 Shift.
REQ-008 SHALL have port OUT_VALID  output  1  head entry present.
REQ-009 SHALL have port OUT_READY  input  1  consumer accepts head.
REQ-010 SHALL have ports OVERFLOW / MULTI_ERR  output  1 each  sticky error flags.
REQ-011 SHALL have port CLR_ERR  input  1  synchronous clear of both sticky flags.

Function
REQ-012 SHALL capture a push when exactly one of the four flags is high, storing that unit's result and 2-bit source code.
REQ-013 SHALL treat zero flags high as no push.
REQ-014 SHALL treat two or more flags high as no push, setting MULTI_ERR on the next edge.
REQ-015 SHALL buffer results in a 2-entry FIFO with occupancy FSM states EMPTY, ONE, TWO.
REQ-016 SHALL transition: EMPTY+push->ONE; ONE+push-pop->TWO; ONE+pop-push->EMPTY; TWO+pop-push->ONE; push+pop->same state; otherwise hold.
REQ-017 SHALL define pop as OUT_VALID && OUT_READY; OUT_VALID high exactly in ONE and TWO.
REQ-018 SHALL present a pushed result on ALU_OUT/ALU_SRC with OUT_VALID one cycle after the flag cycle (latency 1), no combinational flag-to-output path.
REQ-019 SHALL keep ALU_OUT/ALU_SRC stable while OUT_VALID high and OUT_READY low.
REQ-020 SHALL accept push in TWO when pop occurs the same cycle, with no loss and order preserved.
REQ-021 SHALL drop a push in TWO without pop, leave contents unchanged and set OVERFLOW.
REQ-022 SHALL deliver entries strictly in push order, pointer wrap at depth 2.
REQ-023 SHALL give a set event priority over CLR_ERR in the same cycle.

Reset
REQ-024 SHALL on RST asynchronously force state EMPTY, pointers 0, ALU_OUT 0, ALU_SRC 00, OUT_VALID 0, OVERFLOW 0, MULTI_ERR 0, statistics counters 0.
REQ-025 SHALL discard buffered entries when RST asserts mid-operation; first push after release behaves as from EMPTY.

Configuration
REQ-026 SHALL, with macro ALU_RES_STATS_EN defined, add output STAT_CNT (32 bits: four 8-bit saturating counters of accepted pushes, [7:0] Arith .. [31:24] Shift), cleared by RST only.
REQ-027 SHALL, without ALU_RES_STATS_EN, omit STAT_CNT and all counter logic; remaining behaviour identical.

Structure
REQ-028 SHALL place source-code constants (SRC_ARITH..SRC_SHIFT, matching ALU_FUN encoding) and FSM state encodings in shared package alu_pkg.
REQ-029 SHALL implement storage as sub-module alu_res_fifo2 (2-entry FIFO, width DATA_WIDTH+2); flag check, error logic and counters stay in top.

Verification
REQ-030 SHALL cover: Arith_Flag=1, Arith_OUT=0x1234 cycle 0, OUT_READY=1 -> cycle 1 ALU_OUT=0x1234, ALU_SRC=00, OUT_VALID=1; cycle 2 OUT_VALID=0.
REQ-031 SHALL cover: OUT_READY=0, pushes Logic 0x0001, CMP 0x0002, Shift 0x0003 -> OVERFLOW=1, then draining yields 0x0001/01, 0x0002/10 only.
REQ-032 SHALL cover: state TWO, simultaneous pop and Shift push 0x00FF -> no OVERFLOW, order 2nd entry then 0x00FF/11.
REQ-033 SHALL cover: Arith_Flag=Logic_Flag=1 -> no push, MULTI_ERR=1; CLR_ERR=1 next cycle with no error -> MULTI_ERR=0.
REQ-034 SHALL cover: RST asserted with two entries buffered, mid-clock -> OUT_VALID=0 immediately, all outputs 0.
REQ-035 SHALL cover (ALU_RES_STATS_EN): 300 Arith pushes with OUT_READY=1 -> STAT_CNT[7:0]=255, other fields 0.
